// File: rtl/alu_8_bit_if.sv
// Operand/result bundle for the 8-bit registered ALU.
// The master drives operands and the function select; the slave returns the registered result and flag.
interface alu_8_bit_if;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic [3:0] alu_sel;
   logic [7:0] alu_out;
   logic       alu_cout;

   modport master (
      output a,
      output b,
      output cin,
      output alu_sel,
      input  alu_out,
      input  alu_cout
   );

   modport slave (
      input  a,
      input  b,
      input  cin,
      input  alu_sel,
      output alu_out,
      output alu_cout
   );
endinterface

// File: rtl/alu_8_bit.sv
// 8-bit, 16-function ALU with a registered result and carry/borrow/overflow flag.
// Outputs lag their operands by exactly one clock edge; cin only feeds ADD and SUB.
module alu_8_bit (
   input  logic        clk,
   input  logic        rst_n,
   alu_8_bit_if.slave  bus
);

   localparam logic [3:0] SEL_ADD  = 4'h0;
   localparam logic [3:0] SEL_SUB  = 4'h1;
   localparam logic [3:0] SEL_MUL  = 4'h2;
   localparam logic [3:0] SEL_DIV  = 4'h3;
   localparam logic [3:0] SEL_SHL  = 4'h4;
   localparam logic [3:0] SEL_SHR  = 4'h5;
   localparam logic [3:0] SEL_ROL  = 4'h6;
   localparam logic [3:0] SEL_ROR  = 4'h7;
   localparam logic [3:0] SEL_AND  = 4'h8;
   localparam logic [3:0] SEL_OR   = 4'h9;
   localparam logic [3:0] SEL_XOR  = 4'hA;
   localparam logic [3:0] SEL_NOR  = 4'hB;
   localparam logic [3:0] SEL_NAND = 4'hC;
   localparam logic [3:0] SEL_XNOR = 4'hD;
   localparam logic [3:0] SEL_GT   = 4'hE;
   localparam logic [3:0] SEL_EQ   = 4'hF;

   logic [8:0]  sum_s;
   logic [8:0]  diff_s;
   logic [15:0] prod_s;
   logic [7:0]  result_s;
   logic        cout_s;
   logic [7:0]  alu_out_r;
   logic        alu_cout_r;

   // Nine-bit add/subtract so bit 8 carries the carry-out or the borrow.
   always_comb begin
      sum_s  = {1'b0, bus.a} + {1'b0, bus.b} + {8'h00, bus.cin};
      diff_s = {1'b0, bus.a} - {1'b0, bus.b} - {8'h00, bus.cin};
      prod_s = {8'h00, bus.a} * {8'h00, bus.b};
   end

   // Function decode; every path assigns both the result byte and the flag.
   always_comb begin
      result_s = 8'h00;
      cout_s   = 1'b0;
      case (bus.alu_sel)
         SEL_ADD: begin
            result_s = sum_s[7:0];
            cout_s   = sum_s[8];
         end
         SEL_SUB: begin
            result_s = diff_s[7:0];
            cout_s   = diff_s[8];
         end
         SEL_MUL: begin
            result_s = prod_s[7:0];
            cout_s   = (prod_s[15:8] != 8'h00);
         end
         SEL_DIV: begin
            if (bus.b == 8'h00) begin
               result_s = 8'hFF;
               cout_s   = 1'b1;
            end else begin
               result_s = bus.a / bus.b;
               cout_s   = 1'b0;
            end
         end
         SEL_SHL: begin
            result_s = {bus.a[6:0], 1'b0};
            cout_s   = bus.a[7];
         end
         SEL_SHR: begin
            result_s = {1'b0, bus.a[7:1]};
            cout_s   = bus.a[0];
         end
         SEL_ROL: begin
            result_s = {bus.a[6:0], bus.a[7]};
            cout_s   = bus.a[7];
         end
         SEL_ROR: begin
            result_s = {bus.a[0], bus.a[7:1]};
            cout_s   = bus.a[0];
         end
         SEL_AND:  result_s = bus.a & bus.b;
         SEL_OR:   result_s = bus.a | bus.b;
         SEL_XOR:  result_s = bus.a ^ bus.b;
         SEL_NOR:  result_s = ~(bus.a | bus.b);
         SEL_NAND: result_s = ~(bus.a & bus.b);
         SEL_XNOR: result_s = ~(bus.a ^ bus.b);
         SEL_GT:   result_s = (bus.a > bus.b)  ? 8'h01 : 8'h00;
         SEL_EQ:   result_s = (bus.a == bus.b) ? 8'h01 : 8'h00;
         default: begin
            result_s = 8'h00;
            cout_s   = 1'b0;
         end
      endcase
   end

   // Output register; reset clears it immediately, independent of the clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_out_r  <= 8'h00;
         alu_cout_r <= 1'b0;
      end else begin
         alu_out_r  <= result_s;
         alu_cout_r <= cout_s;
      end
   end

   assign bus.alu_out  = alu_out_r;
   assign bus.alu_cout = alu_cout_r;

endmodule

// File: tb/tb_alu_8_bit.sv
// Directed self-checking bench for alu_8_bit: one task per scenario, hand-computed vectors.
`timescale 1ns/1ps
module tb_alu_8_bit;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;

   alu_8_bit_if bus ();

   alu_8_bit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic [3:0] sel);
      bus.a       = a;
      bus.b       = b;
      bus.cin     = cin;
      bus.alu_sel = sel;
   endtask

   // Outputs are sampled 1ns after the active edge; inputs change only there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(8'h55, 8'hAA, 1'b1, 4'h0);
      #2;
      n_cmp++;
      if (bus.alu_out !== 8'h00 || bus.alu_cout !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_async: out=%h cout=%b, want out=00 cout=0", bus.alu_out, bus.alu_cout);
      end
      tick();
      tick();
      n_cmp++;
      if (bus.alu_out !== 8'h00 || bus.alu_cout !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_held: out=%h cout=%b, want out=00 cout=0", bus.alu_out, bus.alu_cout);
      end
      rst_n = 1'b1;
      drive(8'h55, 8'hAA, 1'b0, 4'h0);
      tick();
      n_cmp++;
      if (bus.alu_out !== 8'hFF || bus.alu_cout !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_release: out=%h cout=%b, want out=FF cout=0", bus.alu_out, bus.alu_cout);
      end
   endtask

   task automatic test_sweep();
      logic [7:0] exp_o [16] = '{8'h0C, 8'h08, 8'h14, 8'h05, 8'h14, 8'h05, 8'h14, 8'h05,
                                 8'h02, 8'h0A, 8'h08, 8'hF5, 8'hFD, 8'hF7, 8'h01, 8'h00};
      for (int i = 0; i < 16; i++) begin
         drive(8'h0A, 8'h02, 1'b0, 4'(i));
         tick();
         n_cmp++;
         if (bus.alu_out !== exp_o[i] || bus.alu_cout !== 1'b0) begin
            n_bad++;
            $display("FAIL sweep_sel%0h: out=%h cout=%b, want out=%h cout=0",
                     i, bus.alu_out, bus.alu_cout, exp_o[i]);
         end
      end
   endtask

   // Vector table: {a, b, cin, sel, expected out, expected cout}
   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [3:0] sel;
      logic [7:0] exp_o;
      logic       exp_c;
   } vec_t;

   task automatic test_carry_borrow();
      vec_t v [4] = '{
         '{8'hF6, 8'h0A, 1'b0, 4'h0, 8'h00, 1'b1},
         '{8'hF6, 8'h0A, 1'b1, 4'h0, 8'h01, 1'b1},
         '{8'h02, 8'h0A, 1'b0, 4'h1, 8'hF8, 1'b1},
         '{8'h0A, 8'h0A, 1'b1, 4'h1, 8'hFF, 1'b1}
      };
      for (int i = 0; i < 4; i++) begin
         drive(v[i].a, v[i].b, v[i].cin, v[i].sel);
         tick();
         n_cmp++;
         if (bus.alu_out !== v[i].exp_o || bus.alu_cout !== v[i].exp_c) begin
            n_bad++;
            $display("FAIL carry_borrow_%0d: out=%h cout=%b, want out=%h cout=%b",
                     i, bus.alu_out, bus.alu_cout, v[i].exp_o, v[i].exp_c);
         end
      end
   endtask

   task automatic test_edge_ops();
      vec_t v [10] = '{
         '{8'h37, 8'h00, 1'b0, 4'h3, 8'hFF, 1'b1},
         '{8'hF6, 8'h0A, 1'b1, 4'h2, 8'h9C, 1'b1},
         '{8'h81, 8'h00, 1'b0, 4'h6, 8'h03, 1'b1},
         '{8'h01, 8'h00, 1'b0, 4'h5, 8'h00, 1'b1},
         '{8'h01, 8'h00, 1'b1, 4'h7, 8'h80, 1'b1},
         '{8'h80, 8'h00, 1'b0, 4'h4, 8'h00, 1'b1},
         '{8'hFF, 8'h01, 1'b1, 4'h3, 8'hFF, 1'b0},
         '{8'h02, 8'h0A, 1'b0, 4'hE, 8'h00, 1'b0},
         '{8'h0A, 8'h0A, 1'b0, 4'hF, 8'h01, 1'b0},
         '{8'h10, 8'h10, 1'b0, 4'h2, 8'h00, 1'b1}
      };
      for (int i = 0; i < 10; i++) begin
         drive(v[i].a, v[i].b, v[i].cin, v[i].sel);
         tick();
         n_cmp++;
         if (bus.alu_out !== v[i].exp_o || bus.alu_cout !== v[i].exp_c) begin
            n_bad++;
            $display("FAIL edge_op_%0d: out=%h cout=%b, want out=%h cout=%b",
                     i, bus.alu_out, bus.alu_cout, v[i].exp_o, v[i].exp_c);
         end
      end
   endtask

   // New inputs must not reach the outputs until the following edge.
   task automatic test_back_to_back();
      vec_t v [5] = '{
         '{8'hF6, 8'h0A, 1'b0, 4'h0, 8'h00, 1'b1},
         '{8'hF6, 8'h0A, 1'b0, 4'h1, 8'hEC, 1'b0},
         '{8'hF6, 8'h0A, 1'b0, 4'h2, 8'h9C, 1'b1},
         '{8'hF6, 8'h0A, 1'b0, 4'h3, 8'h18, 1'b0},
         '{8'hF6, 8'h0A, 1'b0, 4'hD, 8'h03, 1'b0}
      };
      logic [7:0] prev_o;
      logic       prev_c;
      prev_o = bus.alu_out;
      prev_c = bus.alu_cout;
      for (int i = 0; i < 5; i++) begin
         drive(v[i].a, v[i].b, v[i].cin, v[i].sel);
         #2;
         n_cmp++;
         if (bus.alu_out !== prev_o || bus.alu_cout !== prev_c) begin
            n_bad++;
            $display("FAIL b2b_hold_%0d: out=%h cout=%b, want out=%h cout=%b",
                     i, bus.alu_out, bus.alu_cout, prev_o, prev_c);
         end
         tick();
         n_cmp++;
         if (bus.alu_out !== v[i].exp_o || bus.alu_cout !== v[i].exp_c) begin
            n_bad++;
            $display("FAIL b2b_load_%0d: out=%h cout=%b, want out=%h cout=%b",
                     i, bus.alu_out, bus.alu_cout, v[i].exp_o, v[i].exp_c);
         end
         prev_o = v[i].exp_o;
         prev_c = v[i].exp_c;
      end
   endtask

   task automatic test_reset_mid();
      drive(8'hF6, 8'h0A, 1'b0, 4'h2);
      tick();
      n_cmp++;
      if (bus.alu_out !== 8'h9C || bus.alu_cout !== 1'b1) begin
         n_bad++;
         $display("FAIL mid_pre: out=%h cout=%b, want out=9C cout=1", bus.alu_out, bus.alu_cout);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (bus.alu_out !== 8'h00 || bus.alu_cout !== 1'b0) begin
         n_bad++;
         $display("FAIL mid_async_clear: out=%h cout=%b, want out=00 cout=0", bus.alu_out, bus.alu_cout);
      end
      tick();
      rst_n = 1'b1;
      drive(8'hF6, 8'h0A, 1'b1, 4'h0);
      tick();
      n_cmp++;
      if (bus.alu_out !== 8'h01 || bus.alu_cout !== 1'b1) begin
         n_bad++;
         $display("FAIL mid_release: out=%h cout=%b, want out=01 cout=1", bus.alu_out, bus.alu_cout);
      end
   endtask

   initial begin
      test_reset();
      test_sweep();
      test_carry_borrow();
      test_edge_ops();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
